// File: rtl/conf_int_mul__pkg.sv
// conf_int_mul__pkg: shared widths, result range bounds and accumulator FSM states
package conf_int_mul__pkg;
   localparam int P_BW   = 32;
   localparam int ACC_BW = 40;
   localparam int LEN_BW = 9;
   localparam int OUT_BW = 32;
   localparam logic signed [31:0] RES_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] RES_MIN = 32'sh8000_0000;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      FULL  = 2'b10
   } state_t;
endpackage

// File: rtl/conf_int_mul__acc_stage_if.sv
// conf_int_mul__acc_stage_if: product input, result output and status bundle of the accumulation stage
interface conf_int_mul__acc_stage_if
   import conf_int_mul__pkg::*;
#(
   parameter int P_BITWIDTH   = P_BW,
   parameter int LEN_BITWIDTH = LEN_BW,
   parameter int OUT_BITWIDTH = OUT_BW
);
   logic signed [P_BITWIDTH-1:0] P;
   logic                         p_valid;
   logic                         p_ready;
   logic [LEN_BITWIDTH-1:0]      dot_len;
   logic                         clear;
   logic [OUT_BITWIDTH-1:0]      result;
   logic                         result_valid;
   logic                         result_ready;
   logic                         busy;
   logic                         ovf;
   logic                         drop_err;
   modport master (
      output P, p_valid, dot_len, clear, result_ready,
      input  p_ready, result, result_valid, busy, ovf, drop_err
   );
   modport slave (
      input  P, p_valid, dot_len, clear, result_ready,
      output p_ready, result, result_valid, busy, ovf, drop_err
   );
endinterface

// File: rtl/conf_int_mul__sat_reduce.sv
// conf_int_mul__sat_reduce: narrows the accumulator to the result width; clamps when CONF_INT_MUL_ACC_SAT_EN is defined, truncates otherwise
module conf_int_mul__sat_reduce
   import conf_int_mul__pkg::*;
#(
   parameter int ACC_BITWIDTH = ACC_BW,
   parameter int OUT_BITWIDTH = OUT_BW
) (
   input  logic signed [ACC_BITWIDTH-1:0] acc,
   output logic [OUT_BITWIDTH-1:0]        result,
   output logic                           ovf
);
`ifdef CONF_INT_MUL_ACC_SAT_EN
   localparam logic signed [ACC_BITWIDTH-1:0] HI = ACC_BITWIDTH'(RES_MAX);
   localparam logic signed [ACC_BITWIDTH-1:0] LO = ACC_BITWIDTH'(RES_MIN);
   logic over, under;
   // clamp into the signed result range and flag when clamping happened
   always_comb begin
      over   = acc > HI;
      under  = acc < LO;
      ovf    = over || under;
      result = OUT_BITWIDTH'(over ? HI : under ? LO : acc);
   end
`else
   logic unused_hi;
   assign result    = acc[OUT_BITWIDTH-1:0];
   assign ovf       = 1'b0;
   assign unused_hi = ^acc[ACC_BITWIDTH-1:OUT_BITWIDTH];
`endif
endmodule

// File: rtl/conf_int_mul__acc_stage.sv
// conf_int_mul__acc_stage: dot-product accumulator behind the multiplier with a one-entry result register (saturation via CONF_INT_MUL_ACC_SAT_EN)
module conf_int_mul__acc_stage
   import conf_int_mul__pkg::*;
#(
   parameter int P_BITWIDTH   = P_BW,
   parameter int ACC_BITWIDTH = ACC_BW,
   parameter int LEN_BITWIDTH = LEN_BW,
   parameter int OUT_BITWIDTH = OUT_BW
) (
   input logic                    clk,
   input logic                    rstP,
   conf_int_mul__acc_stage_if.slave bus
);
   state_t state, state_nx;
   logic signed [ACC_BITWIDTH-1:0] acc, p_ext, sum_nx, red_in;
   logic [LEN_BITWIDTH-1:0]        cnt, len, cnt_nx, len_nx;
   logic                           take, done, out_free, load, drop;
   logic [OUT_BITWIDTH-1:0]        red_res;
   logic                           red_ovf;

   assign bus.p_ready = state != FULL;
   assign bus.busy    = state != IDLE;

   // product acceptance, running sum and completion / output-load decisions
   always_comb begin
      p_ext    = ACC_BITWIDTH'(signed'(bus.P[P_BITWIDTH-1:0]));
      out_free = !bus.result_valid || bus.result_ready;
      take     = bus.p_valid && bus.p_ready && !bus.clear;
      drop     = bus.p_valid && !bus.p_ready && !bus.clear;
      sum_nx   = state == IDLE ? p_ext : acc + p_ext;
      cnt_nx   = state == IDLE ? LEN_BITWIDTH'(1) : cnt + LEN_BITWIDTH'(1);
      len_nx   = state != IDLE ? len : bus.dot_len == '0 ? LEN_BITWIDTH'(1) : bus.dot_len;
      done     = take && cnt_nx == len_nx;
      load     = out_free && !bus.clear && (done || state == FULL);
      red_in   = state == FULL ? acc : sum_nx;
   end

   // next state: clear wins, a finished sum waits in FULL until the output register frees
   always_comb begin
      state_nx = state;
      if (bus.clear)
         state_nx = IDLE;
      else if (done || state == FULL)
         state_nx = out_free ? IDLE : FULL;
      else if (take)
         state_nx = ACCUM;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rstP)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // partial sum, product count and sampled length
   always_ff @(posedge clk) begin
      if (rstP) begin
         acc <= '0;
         cnt <= '0;
         len <= '0;
      end else if (take) begin
         acc <= sum_nx;
         cnt <= cnt_nx;
         len <= len_nx;
      end
   end

   // one-entry output register; a load in the draining cycle replaces the old result seamlessly
   always_ff @(posedge clk) begin
      if (rstP) begin
         bus.result       <= '0;
         bus.ovf          <= 1'b0;
         bus.result_valid <= 1'b0;
      end else if (load) begin
         bus.result       <= red_res;
         bus.ovf          <= red_ovf;
         bus.result_valid <= 1'b1;
      end else if (bus.result_ready) begin
         bus.result_valid <= 1'b0;
      end
   end

   // sticky flag for products offered while the stage was full
   always_ff @(posedge clk) begin
      if (rstP)
         bus.drop_err <= 1'b0;
      else if (drop)
         bus.drop_err <= 1'b1;
   end

   conf_int_mul__sat_reduce #(
      .ACC_BITWIDTH(ACC_BITWIDTH),
      .OUT_BITWIDTH(OUT_BITWIDTH)
   ) u_sat_reduce (
      .acc   (red_in),
      .result(red_res),
      .ovf   (red_ovf)
   );
endmodule
